// File: rtl/stream_rx_pkg.sv
// Shared types and default parameters for the stream receive buffer.
package stream_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } rx_state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_FRAME_LEN = 4;

endpackage

// File: rtl/stream_rx_frame_tracker.sv
// Fixed-length frame delimiter: counts every valid beat (dropped or not) and
// pulses frame_done for one cycle after the FRAME_LEN-th beat.
module stream_rx_frame_tracker
  import stream_rx_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_in,
  output logic frame_done
);

  localparam int CW = $clog2(FRAME_LEN + 1);

  rx_state_t       state_q;
  logic [CW-1:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_q)
        // DONE behaves like IDLE except that it is the pulse cycle
        IDLE, DONE: begin
          if (valid_in) begin
            cnt_q <= CW'(1);
            if (FRAME_LEN == 1) begin
              state_q    <= DONE;
              frame_done <= 1'b1;
            end else begin
              state_q <= ACTIVE;
            end
          end else begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        ACTIVE: begin
          if (valid_in) begin
            if (cnt_q == CW'(FRAME_LEN - 1)) begin
              state_q    <= DONE;
              frame_done <= 1'b1;
              cnt_q      <= CW'(FRAME_LEN);
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/stream_rx_buffer.sv
// Captures a no-backpressure valid-only stream into a DEPTH-entry FWFT buffer
// with ready/valid output. Define STREAM_RX_OVF_COUNT_EN for the ovf_count port.
module stream_rx_buffer
  import stream_rx_pkg::*;
#(
  parameter int               WIDTH         = DEF_WIDTH,
  parameter int               DEPTH         = DEF_DEPTH,
  parameter logic [WIDTH-1:0] INIT_VAL      = '0,
  parameter int               FRAME_LEN     = DEF_FRAME_LEN,
  parameter int               COUNTER_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          data_in,
  input  logic                      valid_in,
  output logic [WIDTH-1:0]          data_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      frame_done,
  output logic                      overflow
`ifdef STREAM_RX_OVF_COUNT_EN
  , output logic [COUNTER_WIDTH-1:0] ovf_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             full, pop, push, drop;

  always_comb begin
    full       = (level_q == LW'(DEPTH));
    pop        = out_valid && out_ready;
    push       = valid_in && (!full || pop);
    drop       = valid_in && full && !pop;
    // power-of-two depth lets the pointers wrap by plain overflow
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    level_d    = level_q + LW'(push) - LW'(pop);
    overflow_d = overflow_q || drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= data_in;
  end

  assign out_valid = (level_q != '0);
  assign data_out  = out_valid ? mem_q[rd_ptr_q] : INIT_VAL;
  assign level     = level_q;
  assign overflow  = overflow_q;

`ifdef STREAM_RX_OVF_COUNT_EN
  logic [COUNTER_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + COUNTER_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_cnt_q <= '0;
    else     ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_count = ovf_cnt_q;
`endif

  stream_rx_frame_tracker #(.FRAME_LEN(FRAME_LEN)) u_frame (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .frame_done (frame_done)
  );

endmodule
